// File: rtl/pipe_stage_chain.sv
// Elastic register chain of DEPTH stages with bubble collapse, flush and gated control.
// Latency: DEPTH cycles through an empty chain; one transaction per cycle sustained.
// Backpressure: in_ready = any empty stage or out_ready (combinational, no skid buffer).
module pipe_stage_chain #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 3,
  parameter int DEPTH  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  // Stage 0 faces the input, stage DEPTH-1 faces the output.
  logic [DEPTH-1:0]  v;
  logic [CTRL_W-1:0] c [DEPTH];
  logic [DATA_W-1:0] d [DEPTH];

  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  up_v;
  logic [CTRL_W-1:0] up_c [DEPTH];
  logic [DATA_W-1:0] up_d [DEPTH];

  // A stage may advance when it, or any stage ahead of it, is empty, or the sink is ready.
  always_comb begin
    logic hole;
    hole = out_ready;
    adv  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hole   = hole | ~v[i];
      adv[i] = hole;
    end
  end

  // Feed for each stage: the chain input for stage 0, the previous stage otherwise.
  always_comb begin
    up_v    = '0;
    up_v[0] = in_valid;
    up_c[0] = in_ctrl;
    up_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_c[i] = c[i-1];
      up_d[i] = d[i-1];
    end
  end

  // Stage registers: reset beats flush; payload only loads when a live transaction arrives.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        c[i] <= '0;
        d[i] <= '0;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) begin
          v[i] <= up_v[i];
          if (up_v[i]) begin
            c[i] <= up_c[i];
            d[i] <= up_d[i];
          end
        end
      end
    end
  end

  // Number of live stages, taken from registered state only.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_ctrl  = out_valid ? c[DEPTH-1] : '0;
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: DEPTH=3 and DEPTH=1 instances against a transaction-list model.
// Latency: model tracks each transaction's position; outputs compared every falling edge.
// Backpressure: random out_ready, flush and reset mixed with directed scenarios.
module tb_pipe_stage_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rstn, iv, ir, ov, ordy, fl;
  logic [2:0]  ic [2];
  logic [2:0]  oc [2];
  logic [47:0] id [2];
  logic [47:0] od [2];
  logic [1:0]  occ0;
  logic [0:0]  occ1;

  pipe_stage_chain #(.DATA_W(48), .CTRL_W(3), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rstn[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_ctrl(ic[0]),
    .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_ctrl(oc[0]),
    .out_data(od[0]), .flush(fl[0]), .occupancy(occ0)
  );

  pipe_stage_chain #(.DATA_W(48), .CTRL_W(3), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rstn[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_ctrl(ic[1]),
    .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_ctrl(oc[1]),
    .out_data(od[1]), .flush(fl[1]), .occupancy(occ1)
  );

  int total = 0;
  int passed = 0;
  bit started = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: ordered list of in-flight transactions (oldest first), each with its stage index.
  typedef struct packed {
    logic [7:0]  pos;
    logic [2:0]  c;
    logic [47:0] d;
  } ent_t;

  ent_t        m [2][8];
  int          cnt [2];
  logic [47:0] lastd [2];

  function automatic int depth_of(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  int  md, lim, p, np;
  bit  inr;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      md = depth_of(k);
      if (!rstn[k]) begin
        cnt[k]   = 0;
        lastd[k] = '0;
      end else if (fl[k]) begin
        cnt[k] = 0;
      end else begin
        inr = (cnt[k] < md) || ordy[k];
        if (cnt[k] > 0 && int'(m[k][0].pos) == md - 1 && ordy[k]) begin
          for (int j = 0; j < cnt[k] - 1; j++) m[k][j] = m[k][j+1];
          cnt[k]--;
        end
        lim = md - 1;
        for (int j = 0; j < cnt[k]; j++) begin
          p  = int'(m[k][j].pos);
          np = (p + 1 < lim) ? p + 1 : lim;
          if (np == md - 1 && p != md - 1) lastd[k] = m[k][j].d;
          m[k][j].pos = 8'(np);
          lim = np - 1;
        end
        if (iv[k] && inr) begin
          m[k][cnt[k]].pos = 8'd0;
          m[k][cnt[k]].c   = ic[k];
          m[k][cnt[k]].d   = id[k];
          cnt[k]++;
          if (md == 1) lastd[k] = id[k];
        end
      end
    end
  end

  // Every falling edge: all outputs of both instances against the model.
  bit          e_ov;
  logic [2:0]  e_oc;
  logic [63:0] a_occ;

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        md   = depth_of(k);
        e_ov = (cnt[k] > 0) && (int'(m[k][0].pos) == md - 1) && !fl[k];
        e_oc = e_ov ? m[k][0].c : 3'd0;
        a_occ = (k == 0) ? 64'(occ0) : 64'(occ1);
        check($sformatf("m%0d out_valid", k), 64'(ov[k]), 64'(e_ov));
        check($sformatf("m%0d out_ctrl", k), 64'(oc[k]), 64'(e_oc));
        check($sformatf("m%0d out_data", k), 64'(od[k]), 64'(lastd[k]));
        check($sformatf("m%0d in_ready", k), 64'(ir[k]), 64'((cnt[k] < md) || ordy[k]));
        check($sformatf("m%0d occupancy", k), a_occ, 64'(cnt[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put0(input logic v, input logic [2:0] c, input logic [47:0] d);
    iv[0] = v; ic[0] = c; id[0] = d;
  endtask

  initial begin
    rstn = 2'b00; iv = '0; ordy = '0; fl = '0;
    for (int k = 0; k < 2; k++) begin ic[k] = '0; id[k] = '0; end

    // 1: reset and idle
    tick(); tick();
    started = 1;
    rstn = 2'b11;
    @(negedge clk);
    check("rst out_valid", 64'(ov[0]), 64'd0);
    check("rst out_ctrl", 64'(oc[0]), 64'd0);
    check("rst out_data", 64'(od[0]), 64'd0);
    check("rst occupancy", 64'(occ0), 64'd0);
    check("rst in_ready", 64'(ir[0]), 64'd1);

    // 2: latency and rate
    tick();
    ordy[0] = 1'b1;
    put0(1, 3'b101, 48'h1); tick();
    put0(1, 3'b101, 48'h2); tick();
    check("lat early valid", 64'(ov[0]), 64'd0);
    put0(1, 3'b101, 48'h3); tick();
    put0(0, 3'b000, 48'h0);
    @(negedge clk);
    check("lat first valid", 64'(ov[0]), 64'd1);
    check("lat first data", 64'(od[0]), 64'h1);
    check("lat first ctrl", 64'(oc[0]), 64'd5);
    tick(); @(negedge clk);
    check("rate second data", 64'(od[0]), 64'h2);
    tick(); @(negedge clk);
    check("rate third data", 64'(od[0]), 64'h3);
    check("rate in_ready", 64'(ir[0]), 64'd1);
    tick();

    // 3: backpressure and bubble collapse
    ordy[0] = 1'b0;
    put0(1, 3'b001, 48'hA); tick();
    put0(0, 3'b000, 48'h0); tick();
    put0(1, 3'b010, 48'hB); tick();
    put0(0, 3'b000, 48'h0); tick();
    @(negedge clk);
    check("bubble occupancy", 64'(occ0), 64'd2);
    check("bubble head", 64'(od[0]), 64'hA);
    put0(1, 3'b011, 48'hC); tick();
    put0(0, 3'b000, 48'h0);
    @(negedge clk);
    check("full occupancy", 64'(occ0), 64'd3);
    check("full in_ready", 64'(ir[0]), 64'd0);
    ordy[0] = 1'b1;
    tick(); @(negedge clk);
    check("drain B", 64'(od[0]), 64'hB);
    tick(); @(negedge clk);
    check("drain C", 64'(od[0]), 64'hC);
    tick(); @(negedge clk);
    check("drain empty", 64'(ov[0]), 64'd0);

    // 4: flush with a full chain
    ordy[0] = 1'b0;
    put0(1, 3'b111, 48'h41); tick();
    put0(1, 3'b111, 48'h42); tick();
    put0(1, 3'b111, 48'h43); tick();
    @(negedge clk);
    check("pre-flush occupancy", 64'(occ0), 64'd3);
    check("pre-flush ctrl", 64'(oc[0]), 64'd7);
    fl[0] = 1'b1; ordy[0] = 1'b1;
    put0(1, 3'b111, 48'h99);
    #1;
    check("flush out_valid", 64'(ov[0]), 64'd0);
    check("flush out_ctrl", 64'(oc[0]), 64'd0);
    tick();
    fl[0] = 1'b0;
    put0(0, 3'b000, 48'h0);
    @(negedge clk);
    check("post-flush occupancy", 64'(occ0), 64'd0);
    tick(); tick(); tick();
    check("flushed input gone", 64'(ov[0]), 64'd0);

    // 5: reset together with flush mid-stream
    ordy[0] = 1'b0;
    put0(1, 3'b110, 48'hE); tick();
    put0(1, 3'b110, 48'hF); tick();
    put0(0, 3'b000, 48'h0);
    rstn[0] = 1'b0; fl[0] = 1'b1;
    tick();
    rstn[0] = 1'b1; fl[0] = 1'b0;
    @(negedge clk);
    check("rst+flush occupancy", 64'(occ0), 64'd0);
    check("rst+flush data", 64'(od[0]), 64'd0);
    ordy[0] = 1'b1;
    put0(1, 3'b100, 48'hD); tick();
    put0(0, 3'b000, 48'h0); tick(); tick();
    @(negedge clk);
    check("after rst D valid", 64'(ov[0]), 64'd1);
    check("after rst D data", 64'(od[0]), 64'hD);
    tick();

    // 6: DEPTH=1 pass-through with a stall
    ordy[1] = 1'b1; iv[1] = 1'b1; ic[1] = 3'd2; id[1] = 48'hAA;
    #1;
    check("d1 in_ready empty", 64'(ir[1]), 64'd1);
    tick();
    ordy[1] = 1'b0; id[1] = 48'hBB;
    @(negedge clk);
    check("d1 stall in_ready", 64'(ir[1]), 64'd0);
    check("d1 stall data", 64'(od[1]), 64'hAA);
    tick();
    @(negedge clk);
    check("d1 held data", 64'(od[1]), 64'hAA);
    ordy[1] = 1'b1;
    #1;
    check("d1 resume in_ready", 64'(ir[1]), 64'd1);
    tick();
    iv[1] = 1'b0;
    @(negedge clk);
    check("d1 next data", 64'(od[1]), 64'hBB);
    check("d1 next valid", 64'(ov[1]), 64'd1);
    tick();

    // Random traffic on both instances
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom_range(0, 9) < 6);
        ic[k]   = 3'($urandom);
        id[k]   = {16'($urandom), 32'($urandom)};
        ordy[k] = ($urandom_range(0, 9) < 5);
        fl[k]   = ($urandom_range(0, 29) == 0);
        rstn[k] = ($urandom_range(0, 99) != 0);
      end
      tick();
    end
    rstn = 2'b11; iv = '0; fl = '0;
    tick(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
Parametrised elastic pipeline register chain: DEPTH back-to-back stages, each holding a valid bit, a CTRL_W control field and a DATA_W payload.
- Moves a transaction one stage per cycle under a valid/ready handshake.
- Collapses bubbles, so an empty stage always accepts even when stages ahead of it are stalled.
- Flush kills every in-flight transaction.
- Used between pipeline stages where the control bits (mem enable, mem write, reg write) must never leak out of a killed or empty slot.

Parameters:
DATA_W, 48, payload width in bits (operand data, immediates, register ids); never gated.
CTRL_W, 3, control field width in bits; forced to zero whenever the output slot is invalid or flushed.
DEPTH, 1, number of register stages (legal range 1 to 8).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-low reset.
in_valid  input  1  upstream holds a transaction.
in_ready  output  1  chain accepts the transaction this cycle.
in_ctrl  input  CTRL_W  control field of the incoming transaction.
in_data  input  DATA_W  payload of the incoming transaction.
out_valid  output  1  stage DEPTH-1 holds a live transaction.
out_ready  input  1  downstream accepts the transaction this cycle.
out_ctrl  output  CTRL_W  control field of stage DEPTH-1, gated.
out_data  output  DATA_W  payload of stage DEPTH-1, ungated.
flush  input  1  kill all in-flight transactions.
occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
Stage storage:
- Stage i (0..DEPTH-1) holds v[i], c[i] and d[i].
- Stage 0 faces the input; stage DEPTH-1 faces the output.

Advance logic (combinational):
- adv[DEPTH-1] = ~v[DEPTH-1] | out_ready.
- adv[i] = ~v[i] | adv[i+1].
- in_ready = adv[0]. in_ready depends combinationally on out_ready; there is no skid buffer.

Stage update on the rising edge, when rst=1 and flush=0:
- If adv[i]=1: v[i] takes the upstream valid (in_valid for i=0, else v[i-1]).
- If adv[i]=1 and the upstream valid is 1: c[i] and d[i] load from upstream. If the upstream valid is 0, c[i] and d[i] hold, to save power.
- If adv[i]=0: the stage holds everything.

Transfers and performance:
- An input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Latency through an empty, unstalled chain is DEPTH cycles: a transaction accepted at edge t is presented at out_valid after edge t+DEPTH-1, and the DEPTH-th edge retires it.
- Sustained throughput is one transaction per cycle.

Flush:
- Next edge: all v clear to 0. c and d hold (don't care).
- An input accepted in the flush cycle is discarded.
- Same cycle: out_valid = v[DEPTH-1] & ~flush and out_ctrl = (v[DEPTH-1] & ~flush) ? c[DEPTH-1] : 0. out_data = d[DEPTH-1] always.
- in_ready is still computed normally during flush.

Reset:
- rst=0 at an edge clears all v, c and d to 0.
- After reset: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
- Reset has priority over flush. Reset mid-stream drops everything, with no partial state.

Occupancy:
- Popcount of v, computed combinationally from registered state.
- Not adjusted for same-cycle flush or transfers.

Boundaries:
- Full chain with out_ready=0: in_ready=0 and all stages hold.
- Full chain with out_ready=1: in_ready=1, so the chain passes through at full rate.
- DEPTH=1: a single register with in_ready = ~v | out_ready.
- out_ready while out_valid=0 has no effect.
- Output ports must never change except at a clock edge or through flush/out_ready gating.

Test Plan:
1. Reset and idle: DEPTH=3; hold rst=0 for 2 edges, then release. Required: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
2. Latency and rate: DEPTH=3, out_ready=1; stream data 0x1,0x2,0x3 with ctrl 3'b101 on consecutive cycles. Required: the first out_valid appears 3 edges after the first accept, then 0x1,0x2,0x3 on consecutive cycles, with in_ready=1 throughout.
3. Backpressure and bubble collapse: DEPTH=3; send A, one idle cycle, then B, with out_ready=0. Required: after A reaches stage 2, B advances into stage 1 (the bubble collapses) and occupancy=2. A third input C fills stage 0, giving occupancy=3 and in_ready=0. After out_ready=1, the outputs are A, B, C in order with no loss or duplication.
4. Flush with a full chain: occupancy=3 and out_valid=1 with ctrl=3'b111. Assert flush for 1 cycle while in_valid=1. Required: out_valid=0 and out_ctrl=0 in the same cycle. Next cycle, occupancy=0 and out_valid=0, and the input from the flush cycle never appears.
5. Reset over flush mid-stream: with 2 valid stages, assert rst=0 and flush=1 together. Required: all state is zero next cycle; a new input D then emerges after DEPTH cycles unaffected.
6. DEPTH=1 pass-through: out_ready toggles 1,0,1 while in_valid=1 with data 0xAA,0xBB. Required: in_ready follows ~v|out_ready, and 0xAA is held during the stall cycle, then 0xBB follows.
